sonar_scan_sequencer: RTL

//  Top-level scan controller for the sonar sweep. Steps the servo position index back and forth

---
 rtl/sonar_scan_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sonar_scan_sequencer.sv
// Sonar sweep controller: steps the servo index back and forth, settles, fires the
// ultrasonic trigger, times the echo and emits one (angle, distance) sample per point.
module sonar_scan_sequencer #(
  parameter int ANGLE_MAX     = 100,
  parameter int SETTLE_CYCLES = 1000000,
  parameter int TRIG_CYCLES   = 500,
  parameter int ECHO_TIMEOUT  = 1500000,
  parameter int DIST_W        = 16,
  parameter int DIST_SHIFT    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              echo,
  output logic [9:0]        servo_pos,
  output logic              trig,
  output logic              busy,
  output logic              sample_valid,
  output logic [9:0]        sample_angle,
  output logic [DIST_W-1:0] sample_dist,
  output logic              sample_timeout
);

  localparam int PH_MAX  = (SETTLE_CYCLES > TRIG_CYCLES) ? SETTLE_CYCLES : TRIG_CYCLES;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int TMO_W   = $clog2(ECHO_TIMEOUT + 1);
  localparam int WID_MIN = DIST_W + DIST_SHIFT;
  // One spare bit above the distance field so the overflow slice is never empty.
  localparam int WID_W   = ((TMO_W > WID_MIN) ? TMO_W : WID_MIN) + 1;

  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  TRIG_LAST   = PH_W'(TRIG_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(ECHO_TIMEOUT - 1);
  localparam logic [9:0]       POS_MAX     = 10'(ANGLE_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_TRIG, S_WAIT_ECHO, S_MEASURE, S_REPORT, S_STEP
  } state_e;

  state_e              state_q;
  logic [PH_W-1:0]     phase_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [WID_W-1:0]    width_q;
  logic                timed_out_q;
  logic                dir_down_q;
  logic [9:0]          servo_pos_q;
  logic                trig_q;
  logic                busy_q;
  logic                sample_valid_q;
  logic [9:0]          sample_angle_q;
  logic [DIST_W-1:0]   sample_dist_q;
  logic                sample_timeout_q;
  logic                echo_meta_q;
  logic                echo_s_q;
  logic                echo_prev_q;

  logic [9:0]          pos_d;
  logic                dir_down_d;
  logic [WID_W-1:0]    width_shifted;
  logic                dist_ovf;

  // Next sweep position; endpoints are visited once per turn.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pos_d      = servo_pos_q;
    dir_down_d = dir_down_q;
    if (!dir_down_q) begin
      if (servo_pos_q == POS_MAX) begin
        dir_down_d = 1'b1;
        pos_d      = servo_pos_q - 10'd1;
      end else begin
        pos_d      = servo_pos_q + 10'd1;
      end
    end else begin
      if (servo_pos_q == 10'd0) begin
        dir_down_d = 1'b0;
        pos_d      = servo_pos_q + 10'd1;
      end else begin
        pos_d      = servo_pos_q - 10'd1;
      end
    end
  end

  assign width_shifted = width_q >> DIST_SHIFT;
  assign dist_ovf      = |width_shifted[WID_W-1:DIST_W];

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      phase_q          <= '0;
      tmo_q            <= '0;
      width_q          <= '0;
      timed_out_q      <= 1'b0;
      dir_down_q       <= 1'b0;
      servo_pos_q      <= '0;
      trig_q           <= 1'b0;
      busy_q           <= 1'b0;
      sample_valid_q   <= 1'b0;
      sample_angle_q   <= '0;
      sample_dist_q    <= '0;
      sample_timeout_q <= 1'b0;
      echo_meta_q      <= 1'b0;
      echo_s_q         <= 1'b0;
      echo_prev_q      <= 1'b0;
    end else begin
      echo_meta_q    <= echo;
      echo_s_q       <= echo_meta_q;
      echo_prev_q    <= echo_s_q;
      sample_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_MOVE;
            phase_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_MOVE: begin
          if (phase_q == SETTLE_LAST) begin
            state_q <= S_TRIG;
            phase_q <= '0;
            trig_q  <= 1'b1;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        S_TRIG: begin
          if (phase_q == TRIG_LAST) begin
            state_q <= S_WAIT_ECHO;
            trig_q  <= 1'b0;
            tmo_q   <= '0;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        S_WAIT_ECHO: begin
          if (tmo_q == TMO_LAST) begin
            state_q     <= S_REPORT;
            timed_out_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
            // Only a fresh rising edge counts; a level already high on entry is ignored.
            if (echo_s_q && !echo_prev_q) begin
              state_q <= S_MEASURE;
              width_q <= WID_W'(1);
            end
          end
        end
        S_MEASURE: begin
          if (tmo_q == TMO_LAST) begin
            state_q     <= S_REPORT;
            timed_out_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
            if (echo_s_q) begin
              if (width_q != '1) width_q <= width_q + WID_W'(1);
            end else begin
              state_q     <= S_REPORT;
              timed_out_q <= 1'b0;
            end
          end
        end
        S_REPORT: begin
          state_q          <= S_STEP;
          sample_valid_q   <= 1'b1;
          sample_angle_q   <= servo_pos_q;
          sample_timeout_q <= timed_out_q;
          sample_dist_q    <= (timed_out_q || dist_ovf) ? '1 : width_shifted[DIST_W-1:0];
        end
        S_STEP: begin
          servo_pos_q <= pos_d;
          dir_down_q  <= dir_down_d;
          phase_q     <= '0;
          busy_q      <= enable;
          state_q     <= enable ? S_MOVE : S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          trig_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign servo_pos      = servo_pos_q;
  assign trig           = trig_q;
  assign busy           = busy_q;
  assign sample_valid   = sample_valid_q;
  assign sample_angle   = sample_angle_q;
  assign sample_dist    = sample_dist_q;
  assign sample_timeout = sample_timeout_q;

endmodule
